// File: rtl/clk_phase_ctrl.sv
// Two-phase non-overlapping clock-enable sequencer (IDLE/PH1/GAP1/PH2/GAP2) with start/stop handshake.
// Optional burst limit enabled by defining CLK_PHASE_CTRL_BURST_EN.
module clk_phase_ctrl #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned GUARD = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div_ratio,
`ifdef CLK_PHASE_CTRL_BURST_EN
    input  logic [CNT_W-1:0] burst_len,
`endif
    output logic             busy,
    output logic             ce_v1,
    output logic             ce_v2,
    output logic             done,
    output logic [CNT_W-1:0] periods
);

    typedef enum logic [2:0] {StIdle, StPh1, StGap1, StPh2, StGap2} state_e;

    localparam logic [3:0] GuardM1 = (GUARD == 0) ? 4'd0 : 4'(GUARD - 1);

    state_e           state_q;
    logic [DIV_W-1:0] len_m1_q;
    logic [DIV_W-1:0] cnt_q;
    logic [3:0]       gcnt_q;
    logic             stop_q;

    logic [DIV_W-1:0] div_m1;
    logic [CNT_W-1:0] periods_inc;
    logic             period_end;
    logic             burst_hit;
    logic             stop_any;

    // Counters hold length-1 so a zero div_ratio naturally yields 1-cycle phases.
    assign div_m1      = (div_ratio == '0) ? '0 : div_ratio - DIV_W'(1);
    assign periods_inc = (&periods) ? periods : periods + CNT_W'(1);
    assign period_end  = (GUARD == 0) ? (state_q == StPh2 && cnt_q == '0)
                                      : (state_q == StGap2 && gcnt_q == '0);

`ifdef CLK_PHASE_CTRL_BURST_EN
    logic [CNT_W-1:0] burst_q;
    logic [CNT_W-1:0] decide_cnt;

    // With no gap the decision coincides with the increment, so look at the next count.
    assign decide_cnt = (GUARD == 0) ? periods_inc : periods;
    assign burst_hit  = (burst_q != '0) && (decide_cnt >= burst_q);

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            burst_q <= '0;
        end else if (state_q == StIdle && start && !stop) begin
            burst_q <= burst_len;
        end
    end
`else
    assign burst_hit = 1'b0;
`endif

    assign stop_any = stop_q | stop | burst_hit;

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            len_m1_q <= '0;
            cnt_q    <= '0;
            gcnt_q   <= '0;
            stop_q   <= 1'b0;
            busy     <= 1'b0;
            ce_v1    <= 1'b0;
            ce_v2    <= 1'b0;
            done     <= 1'b0;
            periods  <= '0;
        end else begin
            done <= 1'b0;
            if (stop && state_q != StIdle) begin
                stop_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start && !stop) begin
                        len_m1_q <= div_m1;
                        cnt_q    <= div_m1;
                        periods  <= '0;
                        stop_q   <= 1'b0;
                        busy     <= 1'b1;
                        ce_v1    <= 1'b1;
                        state_q  <= StPh1;
                    end
                end
                StPh1: begin
                    if (cnt_q == '0) begin
                        ce_v1 <= 1'b0;
                        if (GUARD == 0) begin
                            ce_v2   <= 1'b1;
                            cnt_q   <= len_m1_q;
                            state_q <= StPh2;
                        end else begin
                            gcnt_q  <= GuardM1;
                            state_q <= StGap1;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                StGap1: begin
                    if (gcnt_q == '0) begin
                        ce_v2   <= 1'b1;
                        cnt_q   <= len_m1_q;
                        state_q <= StPh2;
                    end else begin
                        gcnt_q <= gcnt_q - 4'd1;
                    end
                end
                StPh2: begin
                    if (cnt_q == '0) begin
                        ce_v2   <= 1'b0;
                        periods <= periods_inc;
                        if (GUARD != 0) begin
                            gcnt_q  <= GuardM1;
                            state_q <= StGap2;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                StGap2: begin
                    if (gcnt_q != '0) begin
                        gcnt_q <= gcnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // End of a full period: either wrap to PH1 or retire to IDLE.
            if (period_end) begin
                if (stop_any) begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    stop_q  <= 1'b0;
                    state_q <= StIdle;
                end else begin
                    ce_v1   <= 1'b1;
                    cnt_q   <= len_m1_q;
                    state_q <= StPh1;
                end
            end
        end
    end

endmodule

// File: doc/clk_phase_ctrl.md
# clk_phase_ctrl

Synchronous controller that sequences two non-overlapping clock-enable phases, `ce_v1` and `ce_v2`, from a single free-running clock. It replaces gated-clock generation with enable-based scheduling. Downstream logic stays on `clk_in` and qualifies its registers with the enables. Phase length is programmable, a guard gap separates the phases, and software controls it with a start/stop handshake.

## Interface
- `DIV_W`, 8: width of the phase-length field.
- `GUARD`, 1: idle cycles inserted after each phase (0..15; 0 removes the gap states).
- `CNT_W`, 16: width of the completed-period counter.

- `clk_in`  input  1  single system clock; all logic is on its rising edge.
- `reset_n`  input  1  reset, synchronous and active-low.
- `start`  input  1  one-cycle request to begin phase sequencing.
- `stop`  input  1  one-cycle request for a graceful stop.
- `div_ratio`  input  DIV_W  phase length in cycles; 0 is treated as 1.
- `busy`  output  1  high whenever the FSM is not IDLE.
- `ce_v1`  output  1  phase-1 enable.
- `ce_v2`  output  1  phase-2 enable.
- `done`  output  1  one-cycle pulse when the FSM returns to IDLE.
- `periods`  output  CNT_W  completed PH1+PH2 periods since the last start; saturates at all-ones.

## Operation
- States: IDLE, PH1, GAP1, PH2, GAP2.
- All outputs are registered. While `reset_n`=0 at a clock edge, every output is forced to 0, `periods` clears, the stop flag clears and the state returns to IDLE. This applies in any state, including mid-phase.
- IDLE: `start`=1 and `stop`=0 latch `div_ratio` into `len_q`, clear `periods`, and move to PH1.
- PH1: `ce_v1`=1 for exactly `len_q` cycles, then go to GAP1.
- GAP1: both enables are 0 for GUARD cycles, then go to PH2. With GUARD=0 the FSM goes directly from PH1 to PH2.
- PH2: `ce_v2`=1 for `len_q` cycles, then go to GAP2 (or directly onward with GUARD=0). `periods` increments on the last PH2 cycle.
- GAP2: both enables are 0 for GUARD cycles. Then:
  - stop flag set: go to IDLE, pulse `done`.
  - otherwise: go to PH1.
- Stop handling:
  - `stop` outside IDLE sets a sticky stop flag.
  - The current period always completes through GAP2; no truncated phases.
  - With GUARD=0, the stop decision is taken at the end of PH2.
- Invariant: `ce_v1` and `ce_v2` are never both 1 in any cycle.
- `div_ratio` changes while busy are ignored until the next start.
- `start` while busy is ignored and has no side effects.
- `start` and `stop` together in IDLE: stop wins, the FSM stays in IDLE and `done` does not pulse.
- `stop` in IDLE alone: ignored; the flag is not set.
- Phase counter: one down-counter of DIV_W bits, reloaded at every phase entry. The guard counter is 4 bits.

## Timing
- Start latency: `start` sampled at edge N gives `busy`=1 and `ce_v1`=1 from edge N+1.
- Period length in cycles: 2*max(`div_ratio`,1) + 2*GUARD. Example: `div_ratio`=3, GUARD=1 gives an 8-cycle period.
- `done` goes high in the same cycle that `busy` falls (first IDLE cycle) and lasts exactly one cycle.
- Stop latency: from the `stop` edge to `busy`=0 is at most one full period plus 1 cycle.
- A `start` is accepted in the cycle immediately after the `done` cycle.
- Counter wrap: `periods` holds at 2^CNT_W-1 and does not roll over.

## Configuration
- Macro: `CLK_PHASE_CTRL_BURST_EN`.
- Defined:
  - Adds input `burst_len` [CNT_W-1:0], latched at start.
  - The FSM behaves as if `stop` were asserted once `periods` reaches `burst_len`, and returns to IDLE with `done` after that period's GAP2.
  - `burst_len`=0 means unlimited.
  - A manual `stop` still works.
- Undefined: no `burst_len` port; the controller runs until `stop`.

## Test plan
- Reset mid-run: `div_ratio`=4, start, then `reset_n`=0 during PH2 → next cycle `busy`, `ce_v1`, `ce_v2` and `done` are 0 and `periods`=0; a fresh start works normally.
- Basic sequence: GUARD=1, `div_ratio`=3, start at cycle 0.
  - `ce_v1` high on cycles 1-3 and `ce_v2` high on cycles 5-7.
  - `periods`=1 after cycle 7; the pattern repeats every 8 cycles.
- Graceful stop: `stop` during the 2nd cycle of PH1 in period 2 → PH1, GAP1, PH2 and GAP2 complete, then `done` pulses once, `busy`=0, `periods`=2.
- Edge inputs:
  - `div_ratio`=0 → 1-cycle phases.
  - `start` and `stop` together in IDLE → no activity.
  - `start` while busy → period timing unchanged.
  - A new `div_ratio` applied while busy → ignored.
- Non-overlap plus GUARD=0: `div_ratio`=2 → `ce_v1`/`ce_v2` alternate in 2-cycle blocks with no gap. An assertion checks that `ce_v1`&`ce_v2` is never 1 over 10^4 random start/stop cycles.
- Burst (`CLK_PHASE_CTRL_BURST_EN`): `burst_len`=5, `div_ratio`=2, GUARD=1 → exactly 5 periods (30 cycles of activity), `done` at cycle 31, `periods`=5.
